// File: rtl/seq_multi_adder_pkg.sv
// Shared definitions for the sequential multi-operand adder: FSM state
// encoding and a constant-foldable ceil(log2) helper.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Usable in parameter expressions; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_multi_adder_fsm.sv
// Control FSM for seq_multi_adder: owns state, operand index, busy and the
// result-valid pulse, and tells the datapath when to capture/step/commit.
module seq_adder_fsm
    import adder_pkg::*;
#(
    parameter int N_OPS = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    output logic             busy,
    output logic [IDX_W-1:0] op_sel,
    output logic             output_enable,
    output logic             start,
    output logic             step,
    output logic             last
);

    localparam logic [IDX_W-1:0] LAST_SEL = IDX_W'(N_OPS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] op_sel_q, op_sel_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_sel_q <= '0;
        end else begin
            state_q  <= state_d;
            op_sel_q <= op_sel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_sel_d = op_sel_q;
        start    = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        case (state_q)
            IDLE: begin
                // abort wins over a simultaneous go
                if (go && !abort) begin
                    state_d  = ACCUM;
                    op_sel_d = '0;
                    start    = 1'b1;
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_d  = IDLE;
                    op_sel_d = '0;
                end else begin
                    step = 1'b1;
                    if (op_sel_q == LAST_SEL) begin
                        last     = 1'b1;
                        op_sel_d = '0;
                        state_d  = DONE;
                    end else begin
                        op_sel_d = op_sel_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                op_sel_d = '0;
            end
        endcase
    end

    // Outputs depend on registered state only.
    assign busy          = (state_q != IDLE);
    assign output_enable = (state_q == DONE);
    assign op_sel        = op_sel_q;

endmodule

// File: rtl/seq_multi_adder.sv
// Sequential N_OPS-operand adder/subtractor: captures operands on go, folds one
// operand per cycle into a widened accumulator, and commits the total to sum.
module seq_multi_adder
    import adder_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  N_OPS = 4,
    localparam int IDX_W = clog2(N_OPS),
    localparam int SUM_W = WIDTH + IDX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic                   abort,
    input  logic [N_OPS*WIDTH-1:0] op_in,
    input  logic [N_OPS-1:0]       sub_mask,
    output logic                   busy,
    output logic [IDX_W-1:0]       op_sel,
    output logic [SUM_W-1:0]       sum,
    output logic                   output_enable
);

    logic start, step, last;

    seq_adder_fsm #(
        .N_OPS(N_OPS),
        .IDX_W(IDX_W)
    ) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .abort        (abort),
        .busy         (busy),
        .op_sel       (op_sel),
        .output_enable(output_enable),
        .start        (start),
        .step         (step),
        .last         (last)
    );

    logic [N_OPS*WIDTH-1:0] op_q, op_d;
    logic [N_OPS-1:0]       mask_q, mask_d;
    logic [SUM_W-1:0]       acc_q, acc_d;
    logic [SUM_W-1:0]       sum_q, sum_d;
    logic [WIDTH-1:0]       operand;
    logic [SUM_W-1:0]       operand_ext;
    logic [SUM_W-1:0]       acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            mask_q <= '0;
            acc_q  <= '0;
            sum_q  <= '0;
        end else begin
            op_q   <= op_d;
            mask_q <= mask_d;
            acc_q  <= acc_d;
            sum_q  <= sum_d;
        end
    end

    // Operands are zero-extended; subtraction wraps modulo 2^SUM_W.
    assign operand     = op_q[int'(op_sel)*WIDTH +: WIDTH];
    assign operand_ext = SUM_W'(operand);
    assign acc_next    = mask_q[op_sel] ? (acc_q - operand_ext) : (acc_q + operand_ext);

    always_comb begin
        op_d   = op_q;
        mask_d = mask_q;
        acc_d  = acc_q;
        sum_d  = sum_q;
        if (start) begin
            op_d   = op_in;
            mask_d = sub_mask;
            acc_d  = '0;
        end
        if (step) begin
            acc_d = acc_next;
            if (last) sum_d = acc_next;
        end
    end

    assign sum = sum_q;

endmodule

// File: tb/tb_seq_multi_adder.sv
// Randomized self-checking bench for seq_multi_adder (default, N_OPS=2 and
// N_OPS=16 instances) against a plain-arithmetic reference model.
module tb_seq_multi_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance: WIDTH=8, N_OPS=4
    logic        go = 1'b0, abort = 1'b0;
    logic [31:0] op_in = '0;
    logic [3:0]  sub_mask = '0;
    logic        busy, oe;
    logic [1:0]  op_sel;
    logic [9:0]  sum;

    seq_multi_adder dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .op_in(op_in),
        .sub_mask(sub_mask), .busy(busy), .op_sel(op_sel), .sum(sum),
        .output_enable(oe)
    );

    // WIDTH=16, N_OPS=2
    logic        go1 = 1'b0, ab1 = 1'b0;
    logic [31:0] op1 = '0;
    logic [1:0]  m1 = '0;
    logic        busy1, oe1;
    logic [0:0]  sel1;
    logic [16:0] sum1;

    seq_multi_adder #(.WIDTH(16), .N_OPS(2)) dut1 (
        .clk(clk), .rst(rst), .go(go1), .abort(ab1), .op_in(op1),
        .sub_mask(m1), .busy(busy1), .op_sel(sel1), .sum(sum1),
        .output_enable(oe1)
    );

    // WIDTH=16, N_OPS=16
    logic         go2 = 1'b0, ab2 = 1'b0;
    logic [255:0] op2 = '0;
    logic [15:0]  m2 = '0;
    logic         busy2, oe2;
    logic [3:0]   sel2;
    logic [19:0]  sum2;

    seq_multi_adder #(.WIDTH(16), .N_OPS(16)) dut2 (
        .clk(clk), .rst(rst), .go(go2), .abort(ab2), .op_in(op2),
        .sub_mask(m2), .busy(busy2), .op_sel(sel2), .sum(sum2),
        .output_enable(oe2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: signed running total of the selected operands, wrapped to
    // WIDTH + clog2(N) bits.
    function automatic longint ref_sum(input int n, input int w,
                                       input logic [255:0] ops, input logic [15:0] mask);
        longint acc = 0;
        longint v;
        int     sw  = w + $clog2(n);
        for (int i = 0; i < n; i++) begin
            v = longint'((ops >> (i * w)) & ((256'd1 << w) - 1));
            if (mask[i]) acc = acc - v;
            else         acc = acc + v;
        end
        return acc & ((64'sd1 <<< sw) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    longint model_sum = 0;

    // One full operation on the default instance, checking every cycle.
    task automatic run_op(input logic [31:0] ops, input logic [3:0] mask, input bit abort_in_done);
        longint exp;
        exp      = ref_sum(4, 8, 256'(ops), 16'(mask));
        op_in    = ops;
        sub_mask = mask;
        go       = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            op_in    = $urandom;
            sub_mask = 4'($urandom);
            chk("busy_run", 64'(busy), 64'(1));
            chk("oe_run", 64'(oe), 64'(k == 5));
            if (k < 5) begin
                chk("op_sel_run", 64'(op_sel), 64'(k - 1));
                chk("sum_hold", 64'(sum), 64'(model_sum));
            end else begin
                chk("op_sel_done", 64'(op_sel), 64'(0));
                chk("sum_done", 64'(sum), 64'(exp));
                abort = abort_in_done;
                go    = 1'b1;
            end
            tick();
        end
        abort     = 1'b0;
        go        = 1'b0;
        model_sum = exp;
        chk("busy_after", 64'(busy), 64'(0));
        chk("oe_after", 64'(oe), 64'(0));
        chk("sum_after", 64'(sum), 64'(exp));
        tick();
        chk("go_not_queued", 64'(busy), 64'(0));
    endtask

    logic [31:0] hist_ops[0:17];
    logic [3:0]  hist_mask[0:17];

    initial begin
        int cnt;
        // reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_oe", 64'(oe), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_op_sel", 64'(op_sel), 64'(0));
        chk("rst_sum16", 64'(sum2), 64'(0));

        run_op({8'd40, 8'd30, 8'd20, 8'd10}, 4'b0000, 1'b0);
        run_op(32'hFFFF_FFFF, 4'b0000, 1'b1);
        run_op({8'd0, 8'd0, 8'd7, 8'd5}, 4'b0010, 1'b0);
        run_op({8'd40, 8'd30, 8'd20, 8'd10}, 4'b0000, 1'b0);

        // abort at op_sel=2: back to IDLE, no pulse, sum untouched
        op_in = 32'h0102_0304;
        go    = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        chk("abort_sel", 64'(op_sel), 64'(2));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_oe", 64'(oe), 64'(0));
        chk("abort_sum", 64'(sum), 64'(model_sum));
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_oe", 64'(oe), 64'(0));
            tick();
        end

        // abort wins over go in IDLE
        go    = 1'b1;
        abort = 1'b1;
        tick();
        go    = 1'b0;
        abort = 1'b0;
        chk("abort_go_idle", 64'(busy), 64'(0));

        // go held high: one result every 6 cycles, operands sampled at accept
        for (int e = 0; e < 18; e++) begin
            int c;
            op_in        = $urandom;
            sub_mask     = 4'($urandom);
            hist_ops[e]  = op_in;
            hist_mask[e] = sub_mask;
            go           = 1'b1;
            tick();
            c = e + 1;
            chk("cont_oe", 64'(oe), 64'((c % 6) == 5));
            if ((c % 6) == 5)
                chk("cont_sum", 64'(sum), 64'(ref_sum(4, 8, 256'(hist_ops[c-5]), 16'(hist_mask[c-5]))));
        end
        go        = 1'b0;
        model_sum = ref_sum(4, 8, 256'(hist_ops[12]), 16'(hist_mask[12]));
        tick();

        for (int i = 0; i < 8; i++)
            run_op($urandom, 4'($urandom), i[0]);

        // reset mid-operation
        op_in = $urandom;
        go    = 1'b1;
        tick();
        go = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_sum", 64'(sum), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_op_sel", 64'(op_sel), 64'(0));
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_oe", 64'(oe), 64'(0));
            tick();
        end

        // N_OPS=2, all ones
        op1 = '1;
        m1  = '0;
        go1 = 1'b1;
        tick();
        go1 = 1'b0;
        cnt = 1;
        while (!oe1 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("n2_latency", 64'(cnt), 64'(3));
        chk("n2_sum", 64'(sum1), 64'(2 * 65535));
        tick();

        // N_OPS=16, all ones then a random mixed vector
        for (int t = 0; t < 2; t++) begin
            logic [255:0] ops;
            logic [15:0]  msk;
            if (t == 0) begin
                ops = '1;
                msk = '0;
            end else begin
                for (int i = 0; i < 8; i++) ops[i*32 +: 32] = $urandom;
                msk = 16'($urandom);
            end
            op2 = ops;
            m2  = msk;
            go2 = 1'b1;
            tick();
            go2 = 1'b0;
            op2 = '0;
            cnt = 1;
            while (!oe2 && cnt < 40) begin
                tick();
                cnt++;
            end
            chk("n16_latency", 64'(cnt), 64'(17));
            chk("n16_sum", 64'(sum2), 64'(ref_sum(16, 16, ops, msk)));
            if (t == 0) chk("n16_ones", 64'(sum2), 64'(16 * 65535));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
